// File: rtl/ht_seq_trigger.sv
// Sequential trigger-and-payload test article: counts rising edges of a masked trigger
// condition and XORs a payload mask onto the data path once the threshold is reached.
// Optional macro HT_STICKY_PAYLOAD_EN makes the payload window absorbing.
module ht_seq_trigger #(
   parameter int                 N_TRIG         = 4,
   parameter logic [N_TRIG-1:0]  TRIG_MASK      = 4'b0011,
   parameter int                 THRESHOLD      = 8,
   parameter int                 DATA_W         = 8,
   parameter logic [DATA_W-1:0]  PAYLOAD_MASK   = 8'h01,
   parameter int                 PAYLOAD_CYCLES = 4,
   localparam int                CW             = $clog2(THRESHOLD + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ht_en,
   input  logic [N_TRIG-1:0] trig_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              fire,
   output logic [CW-1:0]     evt_cnt
);

   typedef enum logic {IDLE, FIRE} state_t;

   state_t        state_reg, state_next;
   logic          cond, cond_q, evt_hit;
   logic [CW-1:0] cnt_next;

   assign cond    = ((trig_in & TRIG_MASK) == TRIG_MASK);
   assign evt_hit = cond & ~cond_q;

`ifndef HT_STICKY_PAYLOAD_EN
   localparam int WW = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;
   logic [WW-1:0] win_reg, win_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_reg <= '0;
      end else begin
         win_reg <= win_next;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      cnt_next   = evt_cnt;
`ifndef HT_STICKY_PAYLOAD_EN
      win_next   = win_reg;
`endif
      if (!ht_en) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (evt_hit) begin
                  // Equality before increment: the count never reaches THRESHOLD.
                  if (evt_cnt == CW'(THRESHOLD - 1)) begin
                     state_next = FIRE;
                     cnt_next   = '0;
`ifndef HT_STICKY_PAYLOAD_EN
                     win_next   = WW'(PAYLOAD_CYCLES - 1);
`endif
                  end else begin
                     cnt_next = evt_cnt + CW'(1);
                  end
               end
            end
            FIRE: begin
`ifndef HT_STICKY_PAYLOAD_EN
               if (win_reg == '0) begin
                  state_next = IDLE;
               end else begin
                  win_next = win_reg - WW'(1);
               end
`endif
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         evt_cnt   <= '0;
         cond_q    <= 1'b0;
         fire      <= 1'b0;
         data_out  <= '0;
      end else begin
         state_reg <= state_next;
         evt_cnt   <= cnt_next;
         cond_q    <= ht_en & cond;
         fire      <= (state_next == FIRE);
         data_out  <= data_in ^ ((state_next == FIRE) ? PAYLOAD_MASK : '0);
      end
   end

endmodule

// File: doc/ht_seq_trigger.md
# ht_seq_trigger

Parametrised sequential trigger-and-payload test article for the Trojan-detection benchmark set. It counts rare trigger events on a set of watched nets and, after a programmable number of events, corrupts a data path by XOR with a fixed mask for a bounded window. It sits in-line on a data bus inside a host module. The `ht_en` pin lets the same netlist be characterised as both the golden design and the infected design.

## Interface
Parameters:
- `N_TRIG`, 4: width of the watched trigger bus.
- `TRIG_MASK`, 4'b0011: bits of `trig_in` that must all be 1 for a trigger event; must be non-zero.
- `THRESHOLD`, 8: number of trigger events that arms the payload; range 1..255.
- `DATA_W`, 8: width of the data path.
- `PAYLOAD_MASK`, 8'h01: XOR mask applied to the data during the payload window.
- `PAYLOAD_CYCLES`, 4: length of the payload window in clocks; at least 1.

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ht_en` in 1: 1 enables the trigger logic; 0 gives golden behaviour.
- `trig_in` in `N_TRIG`: watched nets.
- `data_in` in `DATA_W`: clean data.
- `data_out` out `DATA_W`: registered data; corrupted only during the payload window.
- `fire` out 1: registered; high while the payload is applied.
- `evt_cnt` out `CW`: current event count, where `CW` = $clog2(`THRESHOLD`+1).

## Operation
Trigger event:
- Defined as `cond` = ((`trig_in` & `TRIG_MASK`) == `TRIG_MASK`).
- `cond` is sampled each clock into `cond_q`.
- An event is a rising edge: `cond` high and `cond_q` low. A level held high counts once.

State machine with states IDLE and FIRE:
- IDLE:
  - Each event increments `evt_cnt`.
  - When an event would bring the count to `THRESHOLD`, go to FIRE on that edge: `evt_cnt` returns to 0 and the window counter loads `PAYLOAD_CYCLES`-1.
- FIRE:
  - Events are ignored and not counted; `cond_q` still tracks.
  - The window counter decrements each cycle.
  - When it is 0, return to IDLE (or stay, under the macro below).
- `ht_en` = 0 in any state:
  - Next edge forces IDLE.
  - `evt_cnt` and `cond_q` are cleared to 0; no counting occurs.

Data path:
- `data_out` <= `data_in` ^ (FIRE-next ? `PAYLOAD_MASK` : 0).
- `fire` <= FIRE-next.
- `data_out` and `fire` therefore share the same cycle.

Arithmetic:
- `evt_cnt` never exceeds `THRESHOLD`-1 when observed.
- The window counter is $clog2(`PAYLOAD_CYCLES`) bits, minimum 1.
- There is no wrap-around; the compare is equality against `THRESHOLD`-1 before increment.

## Timing
- Reset values: `data_out` = 0, `fire` = 0, `evt_cnt` = 0, state IDLE, `cond_q` = 0.
- Reset mid-FIRE aborts the window immediately (asynchronous).
- Data latency is 1 clock, from `data_in` to `data_out`, in all states.
- Fire latency:
  - The edge that samples the `THRESHOLD`-th event is also the first edge with `fire` = 1.
  - `fire` stays high for exactly `PAYLOAD_CYCLES` consecutive clocks.
- Back-to-back operation: the cycle after FIRE ends, the block is in IDLE with count 0. An event whose edge falls on the first IDLE cycle counts.
- `THRESHOLD` = 1: every counted event fires.
- Simultaneous events: `ht_en` falling on the threshold edge has priority, so no fire occurs.

## Configuration
- `HT_STICKY_PAYLOAD_EN` defined: FIRE is absorbing.
  - `fire` stays 1 and the mask stays applied until `rst` or `ht_en` = 0.
  - The window counter is not implemented.
- Undefined: timed window of `PAYLOAD_CYCLES` clocks as described above.

## Test plan
All scenarios use the default parameters unless stated.
- Golden mode: `ht_en` = 0, toggle `trig_in` between 4'h3 and 4'h0 twenty times, `data_in` = 8'hA5 -> `data_out` = 8'hA5 throughout, with `fire` = 0 and `evt_cnt` = 0.
- Level versus edge: `ht_en` = 1, hold `trig_in` = 4'h3 for 50 cycles -> `evt_cnt` = 1 and no fire.
- Threshold fire:
  - Stimulus: eight 4'h0→4'h3 pulses with `data_in` = 8'h10.
  - Response: on the 8th sampled edge `fire` = 1 and `data_out` = 8'h11 for exactly 4 clocks, then 8'h10 with `evt_cnt` = 0.
- Masking: pulses on `trig_in` = 4'h1 or 4'hC -> no count. Pulses on 4'hF count.
- Events during FIRE: a pulse during the window is not counted. After the window, 8 fresh pulses are required to fire again.
- Reset and disable mid-window:
  - `rst` on the 2nd fire cycle -> `data_out` = 0 and `fire` = 0 at once.
  - `ht_en` low on the threshold edge -> no fire.
  - With `HT_STICKY_PAYLOAD_EN`, `fire` holds for 100 cycles until `rst`.
